// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary encoder emulator: FSM states, quadrature code tables, position width.
package rotary_pkg;

  localparam int unsigned POS_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_Q1    = 3'd1,
    ST_Q2    = 3'd2,
    ST_Q3    = 3'd3,
    ST_Q4    = 3'd4,
    ST_PRESS = 3'd5
  } state_e;

  // {A,B} codes for phases Q1..Q4, first phase in the top bits
  localparam logic [7:0] CW_CODES  = {2'b10, 2'b11, 2'b01, 2'b00};
  localparam logic [7:0] CCW_CODES = {2'b01, 2'b11, 2'b10, 2'b00};

  function automatic logic [1:0] quad_code(input logic dir, input logic [1:0] idx);
    logic [7:0] tbl;
    logic [1:0] code;
    tbl = dir ? CW_CODES : CCW_CODES;
    case (idx)
      2'd0:    code = tbl[7:6];
      2'd1:    code = tbl[5:4];
      2'd2:    code = tbl[3:2];
      default: code = tbl[1:0];
    endcase
    return code;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rotary_phase_timer.sv
// Loadable phase/press down-counter with an optional bounce-segment tick (ROTEMU_BOUNCE_EN).
module rotary_phase_timer
  import rotary_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES  = 50000,
  parameter int unsigned PRESS_CYCLES  = 200000,
  parameter int unsigned BOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic load_press,
  output logic expire_c,
  output logic bounce_tick_c
);

  localparam int unsigned TW = $clog2(max_u(PHASE_CYCLES, PRESS_CYCLES));
  localparam int unsigned BW = $clog2(BOUNCE_CYCLES + 1);

  // Number of glitch edges following each emitted transition (new, old, new)
`ifdef ROTEMU_BOUNCE_EN
  localparam logic [1:0] SEG_EDGES = 2'd2;
`else
  localparam logic [1:0] SEG_EDGES = 2'd0;
`endif

  logic [TW-1:0] count_q, count_d;
  logic [BW-1:0] seg_q, seg_d;
  logic [1:0]    edges_q, edges_d;

  always_comb begin
    count_d = count_q;
    seg_d   = seg_q;
    edges_d = edges_q;
    if (load) begin
      count_d = load_press ? TW'(PRESS_CYCLES - 1) : TW'(PHASE_CYCLES - 1);
      seg_d   = BW'(BOUNCE_CYCLES - 1);
      edges_d = SEG_EDGES;
    end else begin
      if (count_q != '0) count_d = count_q - TW'(1);
      if (edges_q != 2'd0) begin
        if (seg_q == '0) begin
          seg_d   = BW'(BOUNCE_CYCLES - 1);
          edges_d = edges_q - 2'd1;
        end else begin
          seg_d = seg_q - BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      seg_q   <= '0;
      edges_q <= 2'd0;
    end else begin
      count_q <= count_d;
      seg_q   <= seg_d;
      edges_q <= edges_d;
    end
  end

  assign expire_c      = (count_q == '0);
  assign bounce_tick_c = (edges_q != 2'd0) && (seg_q == '0);

endmodule

// File: rtl/rotary_emulator.sv
// Quadrature shaft-encoder emulator: turns step/press commands into ROTA/ROTB/ROTCTR waveforms
// and tracks a reference position. ROTEMU_BOUNCE_EN adds contact chatter on every transition.
module rotary_emulator
  import rotary_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES  = 50000,
  parameter int unsigned PRESS_CYCLES  = 200000,
  parameter int unsigned BOUNCE_CYCLES = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    step_valid,
  input  logic                    step_dir,
  output logic                    step_ready,
  input  logic                    press_valid,
  output logic                    done,
  output logic                    ROTA,
  output logic                    ROTB,
  output logic                    ROTCTR,
  output logic signed [POS_W-1:0] pos
);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [1:0]       ab_q, ab_d;
  logic             ctr_q, ctr_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic [2:0]       mask_q, mask_d;
  logic             load, load_press;
  logic             expire_c, bounce_tick_c;

  rotary_phase_timer #(
    .PHASE_CYCLES (PHASE_CYCLES),
    .PRESS_CYCLES (PRESS_CYCLES),
    .BOUNCE_CYCLES(BOUNCE_CYCLES)
  ) u_timer (
    .clk          (CLK),
    .rst          (RST),
    .load         (load),
    .load_press   (load_press),
    .expire_c     (expire_c),
    .bounce_tick_c(bounce_tick_c)
  );

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    ab_d       = ab_q;
    ctr_d      = ctr_q;
    pos_d      = pos_q;
    done_d     = 1'b0;
    mask_d     = mask_q;
    load       = 1'b0;
    load_press = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // press takes priority; a simultaneous step stays pending
        if (press_valid) begin
          state_d    = ST_PRESS;
          ctr_d      = 1'b1;
          pos_d      = '0;
          load       = 1'b1;
          load_press = 1'b1;
        end else if (step_valid) begin
          state_d = ST_Q1;
          dir_d   = step_dir;
          ab_d    = quad_code(step_dir, 2'd0);
          load    = 1'b1;
        end
      end
      ST_Q1: if (expire_c) begin
        state_d = ST_Q2;
        ab_d    = quad_code(dir_q, 2'd1);
        load    = 1'b1;
      end
      ST_Q2: if (expire_c) begin
        state_d = ST_Q3;
        ab_d    = quad_code(dir_q, 2'd2);
        load    = 1'b1;
      end
      ST_Q3: if (expire_c) begin
        state_d = ST_Q4;
        ab_d    = quad_code(dir_q, 2'd3);
        load    = 1'b1;
      end
      ST_Q4: if (expire_c) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        pos_d   = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
      end
      ST_PRESS: if (expire_c) begin
        state_d = ST_IDLE;
        ctr_d   = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Remember which line just moved so chatter re-toggles only that line
    if (load) begin
      mask_d = {ab_d ^ ab_q, ctr_d & ~ctr_q};
    end else if (bounce_tick_c && (state_d == state_q)) begin
      ab_d  = ab_q ^ mask_q[2:1];
      ctr_d = ctr_q ^ mask_q[0];
    end
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      ab_q    <= 2'b00;
      ctr_q   <= 1'b0;
      pos_q   <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      mask_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      ab_q    <= ab_d;
      ctr_q   <= ctr_d;
      pos_q   <= pos_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      mask_q  <= mask_d;
    end
  end

  assign ROTA       = ab_q[1];
  assign ROTB       = ab_q[0];
  assign ROTCTR     = ctr_q;
  assign pos        = pos_q;
  assign done       = done_q;
  assign step_ready = ready_q;

endmodule

// File: tb/tb_rotary_emulator.sv
// Self-checking bench for rotary_emulator: directed scenarios plus random traffic against a
// cycle-trace reference model built from the encoder waveform rules.
module tb_rotary_emulator;

  localparam int unsigned PHASE = 4;
  localparam int unsigned PRESS = 6;
  localparam int unsigned BNC   = 1;
`ifdef ROTEMU_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif

  logic              CLK;
  logic              RST;
  logic              step_valid, step_dir, step_ready, press_valid, done;
  logic              ROTA, ROTB, ROTCTR;
  logic signed [7:0] pos;

  rotary_emulator #(
    .PHASE_CYCLES (PHASE),
    .PRESS_CYCLES (PRESS),
    .BOUNCE_CYCLES(BNC)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .step_valid (step_valid),
    .step_dir   (step_dir),
    .step_ready (step_ready),
    .press_valid(press_valid),
    .done       (done),
    .ROTA       (ROTA),
    .ROTB       (ROTB),
    .ROTCTR     (ROTCTR),
    .pos        (pos)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] ab;
    logic       ctr;
    logic       done;
    logic       ready;
    logic [7:0] pos;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_pos;
  int         n_total, n_bad;
  bit         req_step, req_press, rand_mode;
  logic       dir_sel;
  int         steps_left;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] ab, input logic ctr, input logic dn,
                              input logic rdy, input logic [7:0] p);
    exp_t e;
    e.ab = ab; e.ctr = ctr; e.done = dn; e.ready = rdy; e.pos = p;
    return e;
  endfunction

  // Expected trace of one step: four phases of PHASE cycles, then the done cycle
  task automatic push_step(input logic dir);
    logic [1:0] seq[4];
    logic [1:0] prev, v;
    if (dir) begin
      seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
    end else begin
      seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
    end
    prev = 2'b00;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < int'(PHASE); i++) begin
        v = (BOUNCE && i >= int'(BNC) && i < int'(2 * BNC)) ? prev : seq[k];
        exp_q.push_back(mk(v, 1'b0, 1'b0, 1'b0, m_pos));
      end
      prev = seq[k];
    end
    m_pos = dir ? m_pos + 8'd1 : m_pos - 8'd1;
    exp_q.push_back(mk(2'b00, 1'b0, 1'b1, 1'b1, m_pos));
  endtask

  task automatic push_press();
    logic c;
    m_pos = 8'd0;
    for (int i = 0; i < int'(PRESS); i++) begin
      c = (BOUNCE && i >= int'(BNC) && i < int'(2 * BNC)) ? 1'b0 : 1'b1;
      exp_q.push_back(mk(2'b00, c, 1'b0, 1'b0, 8'd0));
    end
    exp_q.push_back(mk(2'b00, 1'b0, 1'b1, 1'b1, 8'd0));
  endtask

  // One cycle: check outputs against the model, then drive the next request
  task automatic tick();
    exp_t cur;
    @(negedge CLK);
    if (exp_q.size() != 0) cur = exp_q.pop_front();
    else                   cur = mk(2'b00, 1'b0, 1'b0, 1'b1, m_pos);
    check("ab",    32'({ROTA, ROTB}), 32'(cur.ab));
    check("ctr",   32'(ROTCTR),       32'(cur.ctr));
    check("done",  32'(done),         32'(cur.done));
    check("ready", 32'(step_ready),   32'(cur.ready));
    check("pos",   {24'd0, pos},      {24'd0, cur.pos});
    if (!req_step && !req_press) begin
      if (rand_mode) begin
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) begin
          req_press = 1'b1;
          req_step  = 1'($urandom_range(0, 1));
        end else if (r <= 5) begin
          req_step = 1'b1;
        end
      end else if (steps_left > 0) begin
        req_step = 1'b1;
        steps_left--;
      end
    end
    step_dir    = rand_mode ? 1'($urandom_range(0, 1)) : dir_sel;
    step_valid  = req_step;
    press_valid = req_press;
    if (cur.ready) begin
      if (req_press) begin
        push_press();
        req_press = 1'b0;
      end else if (req_step) begin
        push_step(step_dir);
        req_step = 1'b0;
      end
    end
  endtask

  task automatic drain(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (!req_step && !req_press && steps_left == 0 && exp_q.size() == 0) break;
      tick();
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_ab"},    32'({ROTA, ROTB}), 32'd0);
    check({pfx, "_ctr"},   32'(ROTCTR),       32'd0);
    check({pfx, "_done"},  32'(done),         32'd0);
    check({pfx, "_ready"}, 32'(step_ready),   32'd1);
    check({pfx, "_pos"},   {24'd0, pos},      32'd0);
  endtask

  // Asynchronous reset in the middle of a low clock phase
  task automatic do_reset();
    #1;
    RST         = 1'b1;
    step_valid  = 1'b0;
    press_valid = 1'b0;
    req_step    = 1'b0;
    req_press   = 1'b0;
    steps_left  = 0;
    #1;
    check_reset_vals("arst");
    exp_q.delete();
    m_pos = 8'd0;
    @(posedge CLK);
    #2;
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    step_valid = 1'b0; step_dir = 1'b0; press_valid = 1'b0;
    m_pos = 8'd0; n_total = 0; n_bad = 0;
    req_step = 1'b0; req_press = 1'b0; rand_mode = 1'b0; dir_sel = 1'b1; steps_left = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_vals("por");
    RST = 1'b0;
    repeat (2) tick();

    // single CW step
    dir_sel = 1'b1; steps_left = 1;
    drain(40);
    check("t1_pos", {24'd0, pos}, 32'h01);

    // three back-to-back CCW steps after clearing
    req_press = 1'b1;
    drain(20);
    dir_sel = 1'b0; steps_left = 3;
    drain(100);
    check("t2_pos", {24'd0, pos}, 32'hFD);

    // wrap at +127 / -128
    req_press = 1'b1;
    drain(20);
    dir_sel = 1'b1; steps_left = 127;
    drain(2400);
    check("t3_pos127", {24'd0, pos}, 32'h7F);
    steps_left = 1;
    drain(40);
    check("t3_wrap_up", {24'd0, pos}, 32'h80);
    dir_sel = 1'b0; steps_left = 1;
    drain(40);
    check("t3_wrap_dn", {24'd0, pos}, 32'h7F);

    // simultaneous press and step: press first, then the pending step
    req_press = 1'b1; req_step = 1'b1; dir_sel = 1'b0;
    drain(60);
    check("t4_pos", {24'd0, pos}, 32'hFF);

    // reset during Q3 of a CW step
    req_press = 1'b1;
    drain(20);
    dir_sel = 1'b1; steps_left = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (exp_q.size() == 6) break;
    end
    check("t5_in_q3", 32'(exp_q.size()), 32'd6);
    check("t5_q3_ab", 32'({ROTA, ROTB}), 32'b01);
    do_reset();
    repeat (3) tick();

    // random traffic with occasional resets
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 399) == 0) do_reset();
    end
    rand_mode = 1'b0;
    drain(60);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rotary_emulator.md
# rotary_emulator

Quadrature shaft-encoder emulator: the transmit side of the rotary encoder interface. It converts step and press commands into A/B/center waveforms (ROTA, ROTB, ROTCTR) with the same phase relationship a physical encoder produces. It drives the rotary debouncer/decoder path on-board or in simulation, and keeps a reference position count for self-checking.

## Interface
Parameters:
- PHASE_CYCLES, 50000: clocks per quadrature phase (1 kHz transitions at 50 MHz); legal range ≥ 2.
- PRESS_CYCLES, 200000: clocks ROTCTR is held high per press; legal range ≥ 1.
- BOUNCE_CYCLES, 8: clocks per glitch segment; used only when ROTEMU_BOUNCE_EN is defined.

Ports:
- CLK  in  1  system clock; single clock domain.
- RST  in  1  asynchronous, active-high reset.
- step_valid  in  1  step request.
- step_dir  in  1  direction: 1 = clockwise (increment), 0 = counter-clockwise (decrement).
- step_ready  out  1  high only in IDLE.
- press_valid  in  1  center-press request; accepted only in IDLE.
- done  out  1  one-cycle pulse when a step or press completes.
- ROTA  out  1  quadrature channel A.
- ROTB  out  1  quadrature channel B.
- ROTCTR  out  1  center switch.
- pos  out  8  signed reference position.

## Operation
- Reset values: ROTA=0, ROTB=0, ROTCTR=0, pos=0, done=0, step_ready=1, state=IDLE, timer=0.
- States: IDLE, Q1, Q2, Q3, Q4, PRESS.
- Clockwise step emits the {A,B} sequence 00→10→11→01→00. A rises while B=0.
- Counter-clockwise step emits 00→01→11→10→00. A rises while B=1.
- A compliant decoder therefore counts +1 (CW) or −1 (CCW) on the ROTA rising edge.
- IDLE + press_valid → PRESS.
  - ROTCTR=1 for PRESS_CYCLES clocks.
  - pos cleared to 0 on entry.
  - Then ROTCTR=0, done pulses, return to IDLE.
- IDLE + step_valid (press_valid low) → Q1 with {A,B} at the first code. Each PHASE_CYCLES later, advance Q1→Q2→Q3→Q4, emitting the next code.
- Q4 emits 00. After a further PHASE_CYCLES: pos ±1 (8-bit two's-complement wrap, 127+1=−128, −128−1=127), done pulses, return to IDLE.
- Simultaneous step_valid and press_valid in IDLE: press wins. The step stays pending, with step_ready low until PRESS ends.
- Direction is latched at acceptance. step_dir changes mid-step are ignored.
- ROTA, ROTB and ROTCTR are registered outputs: no combinational path from inputs.
- RST asserted mid-step or mid-press aborts immediately to reset values. No partial pos update.

## Timing
- Handshake: a command is accepted on a rising CLK when valid and ready are both high.
- First output transition appears in the cycle after acceptance (t+1).
- A step occupies exactly 4×PHASE_CYCLES cycles from t+1. done is high at cycle t+4×PHASE_CYCLES+1, and step_ready=1 in that same cycle.
- pos updates in the same cycle done pulses.
- A press occupies PRESS_CYCLES cycles of ROTCTR=1 starting at t+1. done follows in the first cycle with ROTCTR=0.
- Back-to-back steps: a new step may be accepted in the done cycle. No idle gap is required.
- Only one of ROTA/ROTB changes per transition (Gray property), in every mode.

## Configuration
- ROTEMU_BOUNCE_EN defined:
  - Each A/B transition is emitted as new, old, new, each segment BOUNCE_CYCLES long. This injects chatter into the decoder under test.
  - The timer counts the whole PHASE_CYCLES from the first toggle, so total step length is unchanged.
  - Requires PHASE_CYCLES > 3×BOUNCE_CYCLES.
  - ROTCTR also bounces on its rising edge.
- ROTEMU_BOUNCE_EN undefined: clean single transitions, and BOUNCE_CYCLES is unused.

## Structure
- Shared package/include rotary_pkg:
  - state encodings (IDLE, Q1–Q4, PRESS);
  - CW and CCW Gray code tables;
  - POS_W=8.
- One sub-module, rotary_phase_timer.
  - Loadable down-counter sized by $clog2 of max(PHASE_CYCLES, PRESS_CYCLES).
  - Outputs an expiry tick, plus a bounce-segment tick when ROTEMU_BOUNCE_EN is defined.
- The top level holds the FSM, the output registers and pos.

## Test plan
Simulation uses PHASE_CYCLES=4, PRESS_CYCLES=6, BOUNCE_CYCLES=1.
1. After reset, one CW step (dir=1) → {A,B}=10,11,01,00 at t+1, t+5, t+9, t+13; done and pos=1 at t+17.
2. Three CCW steps back-to-back, each accepted in the done cycle → sequence 01,11,10,00 ×3; pos=−3; step_ready low except in done/IDLE cycles.
3. pos=127 then a CW step → pos=−128; then a CCW step → pos=127.
4. step_valid and press_valid together in IDLE → ROTCTR high for 6 cycles and pos=0; the step starts in the cycle after press done.
5. RST asserted during Q3 → all outputs return to reset values immediately; pos unchanged from before the step; step_ready=1.
6. ROTEMU_BOUNCE_EN defined, one CW step → ROTA pattern 1,0,1 on single-cycle segments at t+1..t+3; the done cycle still occurs at t+17.
